store_buffer: RTL
=================

Name: store_buffer

Overview:
- Posted-write buffer between the cpu data port and data_memory.
- Captures cpu stores into a small FIFO and drains them in order to data_memory's write port whenever memory signals ready.
- Forwards buffered data to cpu loads, which are served through data_memory's second read port.
- Decouples the cpu from a slow or enable-gated memory write path.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, address width
- DEPTH, 4, number of buffer entries (power of 2, ≥2)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_write  in  1  store request this cycle
- cpu_addr  in  ADDR_W  store address
- cpu_wdata  in  DATA_W  store data
- cpu_read  in  1  load request this cycle
- cpu_raddr  in  ADDR_W  load address
- cpu_rdata  out  DATA_W  load data (combinational)
- cpu_stall  out  1  store not accepted this cycle; cpu must hold the request
- buf_empty  out  1  no pending stores (used for fences)
- mem_ready  in  1  memory accepts a write this cycle
- mem_write  out  1  write strobe to data_memory
- mem_addr  out  ADDR_W  write address to data_memory
- mem_wdata  out  DATA_W  write data to data_memory
- mem_read2  out  1  read strobe on data_memory port 2
- mem_addr2  out  ADDR_W  read address on port 2
- mem_rdata2  in  DATA_W  port-2 read data, combinational from mem_addr2

Behaviour:
- Reset (reset==0 at rising edge): head=tail=0, count=0, all valid bits cleared. Entry data/address need not be cleared.
- While empty: mem_write=0, cpu_stall=0, buf_empty=1. Reset mid-drain discards all pending stores.
- Storage: circular FIFO, head/tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Drain (pop): pop = (count!=0) && mem_ready.
  - mem_write = pop.
  - mem_addr / mem_wdata = head entry, driven whenever count!=0.
  - On pop, head advances at the clock edge. At most one pop per cycle.
- Push: push = cpu_write && (count<DEPTH || pop).
  - Entry written at tail; tail advances.
  - Full with a simultaneous pop: the push is accepted in the same cycle.
  - count_next = count + push - pop.
- Stall: cpu_stall = cpu_write && count==DEPTH && !pop.
  - Combinational.
  - A stalled store is not captured; the cpu re-presents it.
- Load path:
  - mem_read2 = cpu_read; mem_addr2 = cpu_raddr.
  - cpu_rdata = data of the youngest valid entry whose address equals cpu_raddr (full-width compare), else mem_rdata2.
  - The entry being popped this cycle still participates in forwarding.
  - A store presented in the same cycle as a load to the same address is NOT forwarded; the load is ordered before it.
  - When cpu_read==0, cpu_rdata = mem_rdata2.
- Ordering: memory sees stores in exact acceptance order. Duplicate addresses are not coalesced.
- buf_empty = (count==0), combinational from registered count.
- Latency: a store accepted at edge N is presented on mem_* from cycle N+1. It reaches memory at the first later edge with mem_ready=1.

Test Plan:
1. Reset then idle: hold reset=0 two cycles, release -> buf_empty=1, mem_write=0, cpu_stall=0.
2. Basic drain: mem_ready=0, write (0x10,0xAAAA0001), (0x14,0xAAAA0002); raise mem_ready -> mem_write=1 for exactly 2 cycles with addresses 0x10 then 0x14; then buf_empty=1.
3. Full/stall: mem_ready=0, issue 5 stores (0x20..0x30) -> first 4 accepted, 5th shows cpu_stall=1. Raise mem_ready in the same cycle -> stall drops and the 5th store is accepted together with the pop of 0x20; count stays 4.
4. Forwarding youngest: mem_ready=0, store (0x40,0x1111), (0x44,0x2222), (0x40,0x3333); load 0x40 -> cpu_rdata=0x3333. Load 0x48 -> cpu_rdata equals mem_rdata2.
5. Same-cycle store/load to 0x50 with buffer empty, memory holding 0x5 -> cpu_rdata=0x5. Next cycle load 0x50 -> 0x...new value.
6. Reset mid-operation: 3 pending stores, mem_ready=0, assert reset -> next cycle buf_empty=1, mem_write=0. Raising mem_ready produces no writes.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write buffer: queues cpu stores in a circular FIFO, drains them in order to
// data_memory's write port, and forwards buffered data to cpu loads on read port 2.
module store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              buf_empty,
  input  logic              mem_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read2,
  output logic [ADDR_W-1:0] mem_addr2,
  input  logic [DATA_W-1:0] mem_rdata2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_nonempty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic [PTR_W-1:0]  w_idx;

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = w_nonempty && mem_ready;
  assign w_push     = cpu_write && (!w_full || w_pop);

  assign cpu_stall = cpu_write && w_full && !w_pop;
  assign buf_empty = !w_nonempty;
  assign mem_write = w_pop;
  assign mem_addr  = r_addr[r_head];
  assign mem_wdata = r_data[r_head];
  assign mem_read2 = cpu_read;
  assign mem_addr2 = cpu_raddr;

  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (r_valid[w_idx] && (r_addr[w_idx] == cpu_raddr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_idx];
      end
    end
  end

  assign cpu_rdata = (cpu_read && w_fwd_hit) ? w_fwd_data : mem_rdata2;

  // A push into a full buffer lands on the slot being popped; the push update wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_tail] <= cpu_addr;
      r_data[r_tail] <= cpu_wdata;
    end
  end

endmodule
